// File: rtl/control_sequencer_if.sv
// Control bus between the hard-wired sequencer and the 16-bit datapath.
// The sequencer owns the master side: it observes run/IROut and drives the control word.
interface control_sequencer_if;
  logic        run;
  logic [15:0] ir_out;

  // Combinational control word, decoded from the registered state and IROut
  logic [2:0]  rf_out_a_sel_c;
  logic [2:0]  rf_out_b_sel_c;
  logic [2:0]  rf_fun_sel_c;
  logic [3:0]  rf_reg_sel_c;
  logic [3:0]  rf_scr_sel_c;
  logic [4:0]  alu_fun_sel_c;
  logic        alu_wf_c;
  logic [1:0]  arf_out_c_sel_c;
  logic [1:0]  arf_out_d_sel_c;
  logic [2:0]  arf_fun_sel_c;
  logic [2:0]  arf_reg_sel_c;
  logic        ir_lh_c;
  logic        ir_write_c;
  logic        mem_wr_c;
  logic        mem_cs_c;
  logic [1:0]  mux_a_sel_c;
  logic [1:0]  mux_b_sel_c;
  logic        mux_c_sel_c;

  // Registered status
  logic [2:0]  t;
  logic        halted;
  logic [15:0] instr_count;

  modport master (
    input  run, ir_out,
    output rf_out_a_sel_c, rf_out_b_sel_c, rf_fun_sel_c, rf_reg_sel_c, rf_scr_sel_c,
           alu_fun_sel_c, alu_wf_c, arf_out_c_sel_c, arf_out_d_sel_c, arf_fun_sel_c,
           arf_reg_sel_c, ir_lh_c, ir_write_c, mem_wr_c, mem_cs_c, mux_a_sel_c,
           mux_b_sel_c, mux_c_sel_c, t, halted, instr_count
  );

  modport slave (
    output run, ir_out,
    input  rf_out_a_sel_c, rf_out_b_sel_c, rf_fun_sel_c, rf_reg_sel_c, rf_scr_sel_c,
           alu_fun_sel_c, alu_wf_c, arf_out_c_sel_c, arf_out_d_sel_c, arf_fun_sel_c,
           arf_reg_sel_c, ir_lh_c, ir_write_c, mem_wr_c, mem_cs_c, mux_a_sel_c,
           mux_b_sel_c, mux_c_sel_c, t, halted, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Hard-wired fetch/execute sequencer: two fetch cycles load IR from M[PC], one execute
// cycle decodes a 5-instruction subset (BRA, LD, ST, MOVL, HLT) into the datapath control word.
module control_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  control_sequencer_if.master  bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned OP_W  = 6;

  localparam logic [2:0] RF_LOAD   = 3'b010;
  localparam logic [2:0] ARF_LOAD  = 3'b010;
  localparam logic [2:0] ARF_INC   = 3'b001;
  localparam logic [4:0] ALU_PASSA = 5'b10000;

  localparam logic [OP_W-1:0] OP_BRA  = 6'h00;
  localparam logic [OP_W-1:0] OP_LD   = 6'h01;
  localparam logic [OP_W-1:0] OP_ST   = 6'h02;
  localparam logic [OP_W-1:0] OP_MOVL = 6'h03;
  localparam logic [OP_W-1:0] OP_HLT  = 6'h3F;

  localparam logic [2:0] ARF_SEL_PC = 3'b100;
  localparam logic [1:0] ARF_RD_AR  = 2'b10;
  localparam logic [1:0] MUX_MEM    = 2'b10;
  localparam logic [1:0] MUX_IR_LO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_EX   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [2:0]         t_q;
  logic               halted_q;
  logic [CNT_W-1:0]   instr_count_q;

  logic [15:0]        ir;
  logic [OP_W-1:0]    op;
  logic [1:0]         rx;
  logic [3:0]         rx_onehot;
  logic               unused_ir_lo;

  assign ir        = bus.ir_out;
  assign op        = ir[15:10];
  assign rx        = ir[9:8];
  // R1 is the MSB of the RF write-enable vector
  assign rx_onehot = 4'(4'b1000 >> rx);
  // Low IR byte feeds the datapath muxes directly, never this decoder
  assign unused_ir_lo = ^ir[7:0];

  // Next-state: Run is sampled only in IDLE and at the end of EX
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  state_d = bus.run ? S_F0 : S_IDLE;
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_EX;
      S_EX: begin
        if (op == OP_HLT)  state_d = S_HALT;
        else if (bus.run)  state_d = S_F0;
        else               state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State plus registered status; T and Halted reflect the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      t_q           <= 3'b000;
      halted_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state    <= state_d;
      halted_q <= (state_d == S_HALT);
      case (state_d)
        S_F0:    t_q <= 3'b001;
        S_F1:    t_q <= 3'b010;
        S_EX:    t_q <= 3'b100;
        default: t_q <= 3'b000;
      endcase
      if (state == S_EX) begin
        instr_count_q <= instr_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.t           = t_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = instr_count_q;

  // Control word decode; idle word first so unlisted outputs stay quiet
  always_comb begin
    bus.rf_out_a_sel_c  = 3'b000;
    bus.rf_out_b_sel_c  = 3'b000;
    bus.rf_fun_sel_c    = 3'b000;
    bus.rf_reg_sel_c    = 4'b0000;
    bus.rf_scr_sel_c    = 4'b0000;
    bus.alu_fun_sel_c   = 5'b00000;
    bus.alu_wf_c        = 1'b0;
    bus.arf_out_c_sel_c = 2'b00;
    bus.arf_out_d_sel_c = 2'b00;
    bus.arf_fun_sel_c   = 3'b000;
    bus.arf_reg_sel_c   = 3'b000;
    bus.ir_lh_c         = 1'b0;
    bus.ir_write_c      = 1'b0;
    bus.mem_wr_c        = 1'b0;
    bus.mem_cs_c        = 1'b1;
    bus.mux_a_sel_c     = 2'b00;
    bus.mux_b_sel_c     = 2'b00;
    bus.mux_c_sel_c     = 1'b0;

    case (state)
      S_F0, S_F1: begin
        // Read M[PC] into one IR half and bump PC in the same cycle
        bus.arf_out_d_sel_c = 2'b00;
        bus.mem_cs_c        = 1'b0;
        bus.mem_wr_c        = 1'b0;
        bus.ir_write_c      = 1'b1;
        bus.ir_lh_c         = (state == S_F1);
        bus.arf_reg_sel_c   = ARF_SEL_PC;
        bus.arf_fun_sel_c   = ARF_INC;
      end
      S_EX: begin
        case (op)
          OP_BRA: begin
            bus.mux_b_sel_c   = MUX_IR_LO;
            bus.arf_reg_sel_c = ARF_SEL_PC;
            bus.arf_fun_sel_c = ARF_LOAD;
          end
          OP_LD: begin
            bus.arf_out_d_sel_c = ARF_RD_AR;
            bus.mem_cs_c        = 1'b0;
            bus.mem_wr_c        = 1'b0;
            bus.mux_a_sel_c     = MUX_MEM;
            bus.rf_reg_sel_c    = rx_onehot;
            bus.rf_fun_sel_c    = RF_LOAD;
          end
          OP_ST: begin
            bus.rf_out_a_sel_c  = {1'b0, rx};
            bus.alu_fun_sel_c   = ALU_PASSA;
            bus.mux_c_sel_c     = 1'b0;
            bus.arf_out_d_sel_c = ARF_RD_AR;
            bus.mem_cs_c        = 1'b0;
            bus.mem_wr_c        = 1'b1;
          end
          OP_MOVL: begin
            bus.mux_a_sel_c  = MUX_IR_LO;
            bus.rf_reg_sel_c = rx_onehot;
            bus.rf_fun_sel_c = RF_LOAD;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model (phase, PC, IR, retire count) over a
// small program memory predicts the control word each cycle; directed literals pin key points.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] rf_a;
    logic [2:0] rf_b;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_wr;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
  } cw_t;

  localparam int P_IDLE = 0;
  localparam int P_F0   = 1;
  localparam int P_F1   = 2;
  localparam int P_EX   = 3;
  localparam int P_HALT = 4;

  logic clk;
  logic rst_n;
  logic run;
  int   tests;
  int   fails;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [7:0]  mem [256];
  int          m_ph;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_cnt;

  assign bus.run    = run;
  assign bus.ir_out = m_ir;

  cw_t dut_cw;
  assign dut_cw = {bus.rf_out_a_sel_c, bus.rf_out_b_sel_c, bus.rf_fun_sel_c, bus.rf_reg_sel_c,
                   bus.rf_scr_sel_c, bus.alu_fun_sel_c, bus.alu_wf_c, bus.arf_out_c_sel_c,
                   bus.arf_out_d_sel_c, bus.arf_fun_sel_c, bus.arf_reg_sel_c, bus.ir_lh_c,
                   bus.ir_write_c, bus.mem_wr_c, bus.mem_cs_c, bus.mux_a_sel_c,
                   bus.mux_b_sel_c, bus.mux_c_sel_c};

  function automatic cw_t idle_cw();
    cw_t c;
    c = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  // Control word the instruction set demands for a given phase and IR value
  function automatic cw_t exp_cw(int ph, logic [15:0] ir);
    cw_t c;
    logic [3:0] reg_tab [4];
    logic [1:0] rx;
    reg_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    rx = ir[9:8];
    c = idle_cw();
    if (ph == P_F0 || ph == P_F1) begin
      c.mem_cs  = 1'b0;
      c.ir_wr   = 1'b1;
      c.ir_lh   = (ph == P_F1);
      c.arf_reg = 3'b100;
      c.arf_fun = 3'b001;
    end else if (ph == P_EX) begin
      case (ir[15:10])
        6'h00: begin c.mux_b = 2'b11; c.arf_reg = 3'b100; c.arf_fun = 3'b010; end
        6'h01: begin
          c.arf_d = 2'b10; c.mem_cs = 1'b0; c.mux_a = 2'b10;
          c.rf_reg = reg_tab[rx]; c.rf_fun = 3'b010;
        end
        6'h02: begin
          c.rf_a = {1'b0, rx}; c.alu_fun = 5'b10000; c.arf_d = 2'b10;
          c.mem_cs = 1'b0; c.mem_wr = 1'b1;
        end
        6'h03: begin c.mux_a = 2'b11; c.rf_reg = reg_tab[rx]; c.rf_fun = 3'b010; end
        default: ;
      endcase
    end
    return c;
  endfunction

  function automatic logic [2:0] exp_t(int ph);
    case (ph)
      P_F0:    return 3'b001;
      P_F1:    return 3'b010;
      P_EX:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Instruction-level model of the fetch/execute loop
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph  <= P_IDLE;
      m_pc  <= '0;
      m_ir  <= '0;
      m_cnt <= '0;
    end else begin
      case (m_ph)
        P_IDLE: if (run) m_ph <= P_F0;
        P_F0: begin
          m_ir[7:0] <= mem[m_pc[7:0]];
          m_pc      <= m_pc + 16'd1;
          m_ph      <= P_F1;
        end
        P_F1: begin
          m_ir[15:8] <= mem[m_pc[7:0]];
          m_pc       <= m_pc + 16'd1;
          m_ph       <= P_EX;
        end
        P_EX: begin
          m_cnt <= m_cnt + 16'd1;
          if (m_ir[15:10] == 6'h00) m_pc <= {8'h00, m_ir[7:0]};
          if (m_ir[15:10] == 6'h3F) m_ph <= P_HALT;
          else                      m_ph <= run ? P_F0 : P_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle compare against the model, plus literal spot checks in EX
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cw", 64'(dut_cw), 64'(exp_cw(m_ph, m_ir)));
      chk("t", 64'(bus.t), 64'(exp_t(m_ph)));
      chk("halted", 64'(bus.halted), 64'(m_ph == P_HALT));
      chk("count", 64'(bus.instr_count), 64'(m_cnt));
      if (m_ph == P_EX) begin
        case (m_ir)
          16'h0C01: chk("lit_movl_r1", 64'({dut_cw.mux_a, dut_cw.rf_reg, dut_cw.rf_fun}),
                        64'({2'b11, 4'b1000, 3'b010}));
          16'h060A: chk("lit_ld_r3", 64'({dut_cw.mux_a, dut_cw.rf_reg, dut_cw.arf_d,
                                          dut_cw.mem_cs, dut_cw.mem_wr}),
                        64'({2'b10, 4'b0010, 2'b10, 1'b0, 1'b0}));
          16'h0B00: chk("lit_st_r4", 64'({dut_cw.rf_a, dut_cw.alu_fun, dut_cw.mem_wr,
                                          dut_cw.mem_cs, dut_cw.mux_c}),
                        64'({3'b011, 5'b10000, 1'b1, 1'b0, 1'b0}));
          16'h0020: chk("lit_bra", 64'({dut_cw.mux_b, dut_cw.arf_reg, dut_cw.arf_fun}),
                        64'({2'b11, 3'b100, 3'b010}));
          default: ;
        endcase
      end
      if (m_ph == P_F0 && m_cnt == 16'd5)
        chk("lit_bra_target_pc", 64'(m_pc), 64'h20);
    end
  end

  task automatic wait_ph(int p, logic [15:0] pc, int budget);
    int n;
    n = 0;
    while (!(m_ph == p && m_pc == pc) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_phase_timeout", 64'(m_ph == p && m_pc == pc), 64'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    run   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // MOVL R1,01 / LD R3 / ST R4 / NOP / BRA 20 ; at 0x20: MOVL R2,55 / HLT
    mem[0]  = 8'h01; mem[1]  = 8'h0C;
    mem[2]  = 8'h0A; mem[3]  = 8'h06;
    mem[4]  = 8'h00; mem[5]  = 8'h0B;
    mem[6]  = 8'h00; mem[7]  = 8'h14;
    mem[8]  = 8'h20; mem[9]  = 8'h00;
    mem[32] = 8'h55; mem[33] = 8'h0D;
    mem[34] = 8'h00; mem[35] = 8'hFC;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cw", 64'(dut_cw), 64'(idle_cw()));
    chk("rst_t", 64'(bus.t), 64'h0);
    chk("rst_count", 64'(bus.instr_count), 64'h0);
    chk("rst_halted", 64'(bus.halted), 64'h0);

    // Run until F1 of the ST (PC already at 5), then reset asynchronously mid-cycle
    rst_n = 1'b1;
    run   = 1'b1;
    wait_ph(P_F1, 16'd5, 30);
    chk("pre_rst_count", 64'(bus.instr_count), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cw", 64'(dut_cw), 64'(idle_cw()));
    chk("async_rst_t", 64'(bus.t), 64'h0);
    chk("async_rst_count", 64'(bus.instr_count), 64'h0);

    // Release with Run high: F0 one cycle later, then full program to HALT
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_f0_t", 64'(bus.t), 64'b001);
    wait_ph(P_HALT, 16'h0024, 60);
    chk("halt_flag", 64'(bus.halted), 64'd1);
    chk("halt_count", 64'(bus.instr_count), 64'd7);
    chk("halt_t", 64'(bus.t), 64'h0);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      run = ~run;
    end
    @(posedge clk); #1;
    chk("halt_hold_count", 64'(bus.instr_count), 64'd7);
    chk("halt_hold_cw", 64'(dut_cw), 64'(idle_cw()));

    // Run dropped during F1 of MOVL: instruction completes, then IDLE
    rst_n = 1'b0;
    #1;
    run = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ph(P_F1, 16'd1, 10);
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("drop_t", 64'(bus.t), 64'h0);
    chk("drop_count", 64'(bus.instr_count), 64'd1);
    chk("drop_halted", 64'(bus.halted), 64'd0);
    chk("drop_cw", 64'(dut_cw), 64'(idle_cw()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog @%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
